// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and default geometry for the DVP capture front-end
package cam_pkg;

    // Pixel format, latched once per frame at the vsync falling edge.
    typedef enum logic {
        CAM_YUV_LUMA = 1'b0,
        CAM_RGB565   = 1'b1
    } cam_mode_e;

    // Capture FSM states.
    typedef enum logic [2:0] {
        S_WAIT_CFG  = 3'd0,
        S_SYNC      = 3'd1,
        S_WAIT_HREF = 3'd2,
        S_ACTIVE    = 3'd3,
        S_LINE_END  = 3'd4
    } cap_state_e;

    localparam int CAM_H_ACTIVE = 640;
    localparam int CAM_V_ACTIVE = 480;

endpackage

// File: rtl/cam_byte_pack.sv
// rtl/cam_byte_pack.sv - byte phase tracking and pixel formation from two sensor bytes
//
// Ports:
//   pclk, reset_n  clock / asynchronous active-low reset
//   byte_en        an href-high byte is present on byte_in this cycle
//   phase_clr      force the byte phase back to 0 (drops a dangling byte)
//   rgb_mode       1 = pack {byte0, byte1}, 0 = keep byte0 as luma
//   byte_in        sensor byte
//   phase          current byte phase (1 = byte0 held, waiting for byte1)
//   pixel_done     this cycle's byte completes a pixel
//   pixel          formed pixel, valid when pixel_done
module cam_byte_pack (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        byte_en,
    input  logic        phase_clr,
    input  logic        rgb_mode,
    input  logic [7:0]  byte_in,
    output logic        phase,
    output logic        pixel_done,
    output logic [15:0] pixel
);

    logic       phase_q, phase_d;
    logic [7:0] byte0_q, byte0_d;

    always_comb begin
        phase_d = phase_q;
        byte0_d = byte0_q;
        if (phase_clr) begin
            phase_d = 1'b0;
        end else if (byte_en) begin
            if (!phase_q) begin
                byte0_d = byte_in;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            byte0_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            byte0_q <= byte0_d;
        end
    end

    assign phase      = phase_q;
    assign pixel_done = byte_en & phase_q & ~phase_clr;
    // Luma mode drops the second (chroma) byte.
    assign pixel      = rgb_mode ? {byte0_q, byte_in} : {8'h00, byte0_q};

endmodule

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - DVP camera capture: frame/line FSM, coordinates, markers, error flags
//
// Ports:
//   pclk, reset_n        pixel clock / asynchronous active-low reset
//   config_done          capture enabled while high
//   vsync, href          frame blanking (high) / line active (high)
//   cam_data             sensor byte
//   mode                 0 = YUV422 luma, 1 = RGB565; latched at frame start
//   pix_valid            one-cycle pixel strobe with pix_data, x_coord, y_coord
//   sof                  with the first pix_valid of a frame
//   eol, eof             end-of-line / end-of-frame pulses
//   line_err, frame_err  sticky malformed line / frame flags, cleared at sof
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int V_ACTIVE = CAM_V_ACTIVE,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int PIX_W    = 16
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             config_done,
    input  logic             vsync,
    input  logic             href,
    input  logic [7:0]       cam_data,
    input  logic             mode,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic [X_W-1:0]   x_coord,
    output logic [Y_W-1:0]   y_coord,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             line_err,
    output logic             frame_err
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE);

    cap_state_e       state_q, state_d;
    cam_mode_e        mode_q, mode_d;
    logic             vsync_prev_q;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             sof_pend_q, sof_pend_d;
    logic             pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0] pix_data_q, pix_data_d;
    logic [X_W-1:0]   x_coord_q, x_coord_d;
    logic [Y_W-1:0]   y_coord_q, y_coord_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;
    logic             line_err_q, line_err_d;
    logic             frame_err_q, frame_err_d;

    logic        byte_en;
    logic        phase_clr;
    logic        phase;
    logic        pixel_done;
    logic [15:0] pixel;

    // The byte that raises href is already a pixel byte, so WAIT_HREF accepts it too.
    assign byte_en = config_done & ~vsync & href &
                     ((state_q == S_WAIT_HREF) || (state_q == S_ACTIVE));
    assign phase_clr = ~config_done |
                       (state_q == S_WAIT_CFG) | (state_q == S_SYNC) |
                       (state_q == S_LINE_END) |
                       ((state_q == S_ACTIVE) & vsync);

    cam_byte_pack u_pack (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .byte_en    (byte_en),
        .phase_clr  (phase_clr),
        .rgb_mode   (mode_q == CAM_RGB565),
        .byte_in    (cam_data),
        .phase      (phase),
        .pixel_done (pixel_done),
        .pixel      (pixel)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        x_d         = x_q;
        y_d         = y_q;
        sof_pend_d  = sof_pend_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        x_coord_d   = x_coord_q;
        y_coord_d   = y_coord_q;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        eof_d       = 1'b0;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;

        if (!config_done) begin
            // Losing configuration kills the frame silently: no pixels, no eof.
            state_d    = S_WAIT_CFG;
            x_d        = '0;
            y_d        = '0;
            sof_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_CFG: state_d = S_SYNC;
                S_SYNC: begin
                    // Only a seen 1->0 vsync edge starts a frame, so a partial frame is never taken.
                    if (vsync_prev_q && !vsync) begin
                        mode_d     = cam_mode_e'(mode);
                        x_d        = '0;
                        y_d        = '0;
                        sof_pend_d = 1'b1;
                        state_d    = S_WAIT_HREF;
                    end
                end
                S_WAIT_HREF: begin
                    if (vsync) begin
                        eof_d      = 1'b1;
                        sof_pend_d = 1'b0;
                        if (y_q != Y_MAX) frame_err_d = 1'b1;
                        state_d    = S_SYNC;
                    end else if (href) begin
                        state_d = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (vsync) begin
                        // Frame abort; a coincident href fall still reports its eol.
                        eof_d       = 1'b1;
                        eol_d       = ~href;
                        frame_err_d = 1'b1;
                        sof_pend_d  = 1'b0;
                        state_d     = S_SYNC;
                    end else if (!href) begin
                        eol_d   = 1'b1;
                        state_d = S_LINE_END;
                    end
                end
                S_LINE_END: begin
                    // Lines beyond V_ACTIVE are already flagged as frame errors.
                    if (y_q < Y_MAX && (phase || x_q != X_MAX)) line_err_d = 1'b1;
                    x_d = '0;
                    if (y_q < Y_MAX) y_d = y_q + 1'b1;
                    if (vsync) begin
                        eof_d      = 1'b1;
                        sof_pend_d = 1'b0;
                        if (y_d != Y_MAX) frame_err_d = 1'b1;
                        state_d    = S_SYNC;
                    end else begin
                        state_d = S_WAIT_HREF;
                    end
                end
                default: state_d = S_WAIT_CFG;
            endcase

            if (pixel_done) begin
                if (y_q >= Y_MAX) begin
                    frame_err_d = 1'b1;
                end else if (x_q >= X_MAX) begin
                    line_err_d = 1'b1;
                end else begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = PIX_W'(pixel);
                    x_coord_d   = x_q;
                    y_coord_d   = y_q;
                    x_d         = x_q + 1'b1;
                    if (sof_pend_q) begin
                        sof_d       = 1'b1;
                        sof_pend_d  = 1'b0;
                        line_err_d  = 1'b0;
                        frame_err_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WAIT_CFG;
            mode_q       <= CAM_YUV_LUMA;
            vsync_prev_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            sof_pend_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            x_coord_q    <= '0;
            y_coord_q    <= '0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            vsync_prev_q <= vsync;
            x_q          <= x_d;
            y_q          <= y_d;
            sof_pend_q   <= sof_pend_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            x_coord_q    <= x_coord_d;
            y_coord_q    <= y_coord_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign x_coord   = x_coord_q;
    assign y_coord   = y_coord_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign eof       = eof_q;
    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - self-checking bench for cam_pixel_capture
module tb_cam_pixel_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam int PW = 16;

    logic          pclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          config_done = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          mode = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic [XW-1:0] x_coord;
    logic [YW-1:0] y_coord;
    logic          sof, eol, eof, line_err, frame_err;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    cam_pixel_capture #(
        .H_ACTIVE (H), .V_ACTIVE (V), .X_W (XW), .Y_W (YW), .PIX_W (PW)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .config_done (config_done),
        .vsync       (vsync),
        .href        (href),
        .cam_data    (cam_data),
        .mode        (mode),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    typedef struct packed {
        logic [15:0]   d;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          s;
    } pix_t;

    pix_t got[$];
    int   eol_cnt = 0;
    int   eof_cnt = 0;

    always @(negedge pclk) begin
        if (pix_valid) got.push_back({pix_data, x_coord, y_coord, sof});
        if (eol) eol_cnt++;
        if (eof) eof_cnt++;
    end

    typedef struct {
        logic md;
        int   nlines;
        int   bad_line;
        int   bad_len;
        int   exp_pix;
        logic exp_le;
        logic exp_fe;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] lb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_line(input int len);
        lb.delete();
        href = 1'b1;
        for (int i = 0; i < len; i++) begin
            cam_data = 8'($urandom);
            lb.push_back(cam_data);
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int   bp, be, bo, len;
        pix_t e;
        pix_t exp_q[$];
        bp = got.size();
        be = eol_cnt;
        bo = eof_cnt;
        mode = v.md;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        tick();
        mode = ~v.md;   // must be ignored after frame start
        tick();
        for (int l = 0; l < v.nlines; l++) begin
            len = (l == v.bad_line) ? v.bad_len : 2 * H;
            send_line(len);
            for (int p = 0; p < len / 2; p++) begin
                if (l < V && p < H) begin
                    e.d = v.md ? {lb[2*p], lb[2*p+1]} : {8'h00, lb[2*p]};
                    e.x = XW'(p);
                    e.y = YW'(l);
                    e.s = (exp_q.size() == 0);
                    exp_q.push_back(e);
                end
            end
        end
        end_frame();
        check($sformatf("v%0d_pix_count", idx), got.size() - bp, v.exp_pix);
        for (int i = 0; i < exp_q.size() && bp + i < got.size(); i++)
            check($sformatf("v%0d_pix%0d", idx, i), got[bp+i], exp_q[i]);
        check($sformatf("v%0d_eol_count", idx), eol_cnt - be, v.nlines);
        check($sformatf("v%0d_eof_count", idx), eof_cnt - bo, 1);
        check($sformatf("v%0d_line_err", idx), line_err, v.exp_le);
        check($sformatf("v%0d_frame_err", idx), frame_err, v.exp_fe);
    endtask

    initial begin
        int bp, bo;

        vecs[0] = '{1'b1, 4, -1, 0,  32, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4, -1, 0,  32, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4,  2, 15, 31, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4,  1, 18, 32, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 3, -1, 0,  24, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 5, -1, 0,  32, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 4,  0, 14, 31, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 4, -1, 0,  32, 1'b0, 1'b0};

        // Reset state
        repeat (2) tick();
        check("reset_outputs", {pix_valid, pix_data, x_coord, y_coord, sof, eol, eof, line_err, frame_err}, 0);
        reset_n = 1'b1;
        config_done = 1'b1;
        mode = 1'b1;

        // First pixel latency and sof
        start_frame();
        bp = got.size();
        href = 1'b1;
        cam_data = 8'hA5;
        tick();
        @(negedge pclk);
        check("lat_no_early_valid", pix_valid, 0);
        cam_data = 8'h3C;
        tick();
        @(negedge pclk);
        check("lat_valid", pix_valid, 1);
        check("lat_data", pix_data, 16'hA53C);
        check("lat_sof", sof, 1);
        check("lat_xy", {x_coord, y_coord}, 0);
        for (int i = 0; i < 2 * H - 2; i++) begin
            cam_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
        for (int l = 1; l < V; l++) send_line(2 * H);
        end_frame();
        check("lat_frame_count", got.size() - bp, V * H);
        check("lat_errs", {line_err, frame_err}, 0);

        // Table of whole frames
        for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

        // Capture enabled mid-frame: nothing until the next vsync fall
        config_done = 1'b0;
        start_frame();
        bp = got.size();
        bo = eof_cnt;
        send_line(2 * H);
        href = 1'b1;
        for (int i = 0; i < 2 * H; i++) begin
            if (i == 5) config_done = 1'b1;
            cam_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
        send_line(2 * H);
        send_line(2 * H);
        end_frame();
        check("midstart_no_pix", got.size() - bp, 0);
        check("midstart_no_eof", eof_cnt - bo, 0);
        run_frame(10, vecs[0]);

        // vsync rises mid-line: eof next cycle, frame_err
        start_frame();
        send_line(2 * H);
        send_line(2 * H);
        href = 1'b1;
        repeat (6) begin
            cam_data = 8'($urandom);
            tick();
        end
        vsync = 1'b1;
        tick();
        @(negedge pclk);
        check("abort_eof", eof, 1);
        check("abort_frame_err", frame_err, 1);
        tick();
        @(negedge pclk);
        check("abort_eof_one_cycle", eof, 0);
        href = 1'b0;
        repeat (3) tick();
        run_frame(11, vecs[1]);

        // href fall and vsync rise together
        start_frame();
        for (int l = 0; l < V - 1; l++) send_line(2 * H);
        href = 1'b1;
        repeat (2 * H) begin
            cam_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        vsync = 1'b1;
        tick();
        @(negedge pclk);
        check("simul_eol", eol, 1);
        check("simul_eof", eof, 1);
        repeat (3) tick();
        run_frame(12, vecs[0]);

        // Asynchronous reset mid-line
        start_frame();
        send_line(2 * H);
        href = 1'b1;
        repeat (6) begin
            cam_data = 8'($urandom);
            tick();
        end
        #1 reset_n = 1'b0;
        #1 check("rst_async_outputs", {pix_valid, pix_data, x_coord, y_coord, sof, eol, eof, line_err, frame_err}, 0);
        tick();
        reset_n = 1'b1;
        bp = got.size();
        bo = eof_cnt;
        repeat (10) begin
            cam_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
        send_line(2 * H);
        send_line(2 * H);
        end_frame();
        check("rst_no_pix", got.size() - bp, 0);
        check("rst_no_eof", eof_cnt - bo, 0);
        run_frame(13, vecs[1]);

        // config_done dropped mid-line
        start_frame();
        send_line(2 * H);
        href = 1'b1;
        repeat (4) begin
            cam_data = 8'($urandom);
            tick();
        end
        config_done = 1'b0;
        tick();
        config_done = 1'b1;
        bp = got.size();
        bo = eof_cnt;
        repeat (12) begin
            cam_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        repeat (3) tick();
        send_line(2 * H);
        end_frame();
        check("cfgdrop_no_pix", got.size() - bp, 0);
        check("cfgdrop_no_eof", eof_cnt - bo, 0);
        run_frame(14, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
